// File: rtl/mux_rr_arbiter.sv
// rtl/mux_rr_arbiter.sv - round-robin arbiter owning the select of a shared 4:1 mux
module mux_rr_arbiter #(
    parameter int MAX_HOLD = 4
) (
    input  logic       CLK,
    input  logic       RESET_N,
    input  logic [3:0] REQ,
    input  logic [3:0] X,
    output logic [3:0] GNT,
    output logic [1:0] C,
    output logic       VALID,
    output logic       Y,
    output logic [3:0] CNT
);

    localparam logic [3:0] LP_LAST = 4'(MAX_HOLD - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [1:0] r_c;
    logic [1:0] w_c_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    logic [3:0] r_gnt;
    logic [3:0] w_gnt_nxt;

    logic       w_found;
    logic [1:0] w_winner;
    logic [1:0] w_probe;

    // Search from C+1 upward with wrap; scanning high-to-low offsets lets the nearest hit win.
    always_comb begin
        w_found  = 1'b0;
        w_winner = r_c;
        w_probe  = 2'b00;
        for (int k = 4; k >= 1; k--) begin
            w_probe = r_c + k[1:0];
            if (REQ[w_probe]) begin
                w_found  = 1'b1;
                w_winner = w_probe;
            end
        end
    end

    // Next-state logic: release beats quantum expiry, otherwise the grant keeps counting.
    always_comb begin
        w_state_nxt = r_state;
        w_c_nxt     = r_c;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_state_nxt = ST_GRANT;
                    w_c_nxt     = w_winner;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ST_GRANT: begin
                if (!REQ[r_c]) begin
                    w_cnt_nxt = 4'd0;
                    if (w_found) begin
                        w_c_nxt = w_winner;
                    end else begin
                        w_state_nxt = ST_IDLE;
                    end
                end else if (r_cnt == LP_LAST) begin
                    // REQ[C] is high here, so the search always finds someone (possibly C again).
                    w_c_nxt   = w_winner;
                    w_cnt_nxt = 4'd0;
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
        w_gnt_nxt = (w_state_nxt == ST_GRANT) ? (4'b0001 << w_c_nxt) : 4'b0000;
    end

    // State registers; reset clears the grant immediately.
    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            r_state <= ST_IDLE;
            r_c     <= 2'b11;
            r_cnt   <= 4'd0;
            r_gnt   <= 4'b0000;
        end else begin
            r_state <= w_state_nxt;
            r_c     <= w_c_nxt;
            r_cnt   <= w_cnt_nxt;
            r_gnt   <= w_gnt_nxt;
        end
    end

    assign GNT   = r_gnt;
    assign C     = r_c;
    assign CNT   = r_cnt;
    assign VALID = (r_state == ST_GRANT);
    assign Y     = VALID ? X[r_c] : 1'b0;

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// tb/tb_mux_rr_arbiter.sv - directed self-checking bench for mux_rr_arbiter
module tb_mux_rr_arbiter;

    logic       CLK;
    logic       RESET_N;
    logic [3:0] REQ;
    logic [3:0] X;
    logic [3:0] GNT;
    logic [1:0] C;
    logic       VALID;
    logic       Y;
    logic [3:0] CNT;

    int total;
    int bad;

    mux_rr_arbiter #(.MAX_HOLD(4)) dut (
        .CLK    (CLK),
        .RESET_N(RESET_N),
        .REQ    (REQ),
        .X      (X),
        .GNT    (GNT),
        .C      (C),
        .VALID  (VALID),
        .Y      (Y),
        .CNT    (CNT)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        RESET_N = 1'b0;
        REQ     = 4'b0000;
        #2;
        RESET_N = 1'b1;
    endtask

    task automatic test_reset();
        RESET_N = 1'b0;
        REQ     = 4'b1111;
        X       = 4'b1010;
        tick();
        tick();
        total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL rst_gnt got=%b exp=0000", GNT); end
        total++; if (VALID !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b exp=0", VALID); end
        total++; if (C !== 2'd3) begin bad++; $display("FAIL rst_c got=%0d exp=3", C); end
        total++; if (Y !== 1'b0) begin bad++; $display("FAIL rst_y got=%b exp=0", Y); end
        total++; if (CNT !== 4'd0) begin bad++; $display("FAIL rst_cnt got=%0d exp=0", CNT); end
        RESET_N = 1'b1;
        tick();
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL rst_first_gnt got=%b exp=0001", GNT); end
        total++; if (C !== 2'd0) begin bad++; $display("FAIL rst_first_c got=%0d exp=0", C); end
        total++; if (Y !== 1'b0) begin bad++; $display("FAIL rst_first_y got=%b exp=0", Y); end
        total++; if (VALID !== 1'b1) begin bad++; $display("FAIL rst_first_valid got=%b exp=1", VALID); end
    endtask

    task automatic test_single_release();
        do_reset();
        REQ = 4'b0100;
        X   = 4'b0100;
        for (int k = 0; k < 2; k++) begin
            tick();
            total++; if (GNT !== 4'b0100) begin bad++; $display("FAIL single_gnt cyc=%0d got=%b exp=0100", k, GNT); end
            total++; if (Y !== 1'b1) begin bad++; $display("FAIL single_y cyc=%0d got=%b exp=1", k, Y); end
            total++; if (CNT !== 4'(k)) begin bad++; $display("FAIL single_cnt cyc=%0d got=%0d exp=%0d", k, CNT, k); end
        end
        X = 4'b0000;
        #1;
        total++; if (Y !== 1'b0) begin bad++; $display("FAIL single_y_comb got=%b exp=0", Y); end
        X   = 4'b0100;
        REQ = 4'b0000;
        tick();
        total++; if (VALID !== 1'b0) begin bad++; $display("FAIL single_idle_valid got=%b exp=0", VALID); end
        total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL single_idle_gnt got=%b exp=0000", GNT); end
        total++; if (C !== 2'd2) begin bad++; $display("FAIL single_idle_c got=%0d exp=2", C); end
        total++; if (Y !== 1'b0) begin bad++; $display("FAIL single_idle_y got=%b exp=0", Y); end
    endtask

    task automatic test_rotation();
        logic [3:0] exp_gnt;
        int         order [5];
        order = '{0, 1, 2, 3, 0};
        do_reset();
        REQ = 4'b1111;
        tick();
        for (int g = 0; g < 5; g++) begin
            exp_gnt = 4'b0001 << order[g];
            for (int k = 0; k < 4; k++) begin
                total++; if (GNT !== exp_gnt) begin bad++; $display("FAIL rot_gnt slot=%0d cyc=%0d got=%b exp=%b", g, k, GNT, exp_gnt); end
                total++; if (CNT !== 4'(k)) begin bad++; $display("FAIL rot_cnt slot=%0d cyc=%0d got=%0d exp=%0d", g, k, CNT, k); end
                tick();
            end
        end
    endtask

    task automatic test_quantum_regrant();
        do_reset();
        REQ = 4'b0010;
        tick();
        for (int k = 0; k < 10; k++) begin
            total++; if (GNT !== 4'b0010) begin bad++; $display("FAIL quant_gnt cyc=%0d got=%b exp=0010", k, GNT); end
            total++; if (CNT !== 4'(k % 4)) begin bad++; $display("FAIL quant_cnt cyc=%0d got=%0d exp=%0d", k, CNT, k % 4); end
            tick();
        end
    endtask

    task automatic test_simul_release();
        do_reset();
        REQ = 4'b0100;
        tick();
        total++; if (GNT !== 4'b0100) begin bad++; $display("FAIL simul_hold2 got=%b exp=0100", GNT); end
        REQ = 4'b1001;
        tick();
        total++; if (GNT !== 4'b1000) begin bad++; $display("FAIL simul_next3 got=%b exp=1000", GNT); end
        total++; if (CNT !== 4'd0) begin bad++; $display("FAIL simul_cnt got=%0d exp=0", CNT); end
        tick();
        total++; if (GNT !== 4'b1000) begin bad++; $display("FAIL simul_keep3 got=%b exp=1000", GNT); end
        REQ = 4'b0001;
        tick();
        total++; if (GNT !== 4'b0001) begin bad++; $display("FAIL simul_then0 got=%b exp=0001", GNT); end
        total++; if (C !== 2'd0) begin bad++; $display("FAIL simul_c0 got=%0d exp=0", C); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        REQ = 4'b1000;
        tick();
        tick();
        tick();
        total++; if (GNT !== 4'b1000 || CNT !== 4'd2) begin bad++; $display("FAIL midrst_pre got=%b/%0d exp=1000/2", GNT, CNT); end
        #1;
        RESET_N = 1'b0;
        #1;
        total++; if (GNT !== 4'b0000) begin bad++; $display("FAIL midrst_gnt got=%b exp=0000", GNT); end
        total++; if (VALID !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%b exp=0", VALID); end
        total++; if (C !== 2'd3) begin bad++; $display("FAIL midrst_c got=%0d exp=3", C); end
        total++; if (CNT !== 4'd0) begin bad++; $display("FAIL midrst_cnt got=%0d exp=0", CNT); end
        RESET_N = 1'b1;
        tick();
        total++; if (GNT !== 4'b1000) begin bad++; $display("FAIL midrst_regrant got=%b exp=1000", GNT); end
        total++; if (CNT !== 4'd0) begin bad++; $display("FAIL midrst_regrant_cnt got=%0d exp=0", CNT); end
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        RESET_N = 1'b0;
        REQ     = 4'b0000;
        X       = 4'b0000;
        test_reset();
        test_single_release();
        test_rotation();
        test_quantum_regrant();
        test_simul_release();
        test_reset_mid_grant();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mux_rr_arbiter.md
# mux_rr_arbiter

Round-robin arbiter that shares the 4:1 multiplexer between four single-bit requesters. It drives the multiplexer select `C` and the output `Y` through an internal 4:1 mux. Grants are one-hot and bounded by a hold quantum, so no requester can hold the shared output forever. It sits in front of the 4:1 mux datapath and owns its select line.

## Interface
- `MAX_HOLD`, default 4: maximum consecutive cycles one grant may last while any request is pending; legal range 1–15.
- `CLK` input 1: single clock; all state updates on the rising edge.
- `RESET_N` input 1: reset, asynchronous assert, active-low. While low, all state is held at reset values.
- `REQ` input 4: `REQ[i]` high means requester i wants the mux. The requester holds it high until it has finished.
- `X` input 4: data bit from each requester; `X[i]` belongs to requester i.
- `GNT` output 4: one-hot grant, or all zero when no grant is active.
- `C` output 2: mux select, equal to the index of the current or last granted requester.
- `VALID` output 1: high while a grant is active.
- `Y` output 1: equals `X[C]` when `VALID` is high, otherwise 0. This path is combinational from `X`.
- `CNT` output 4: cycles already spent in the current grant, from 0 to `MAX_HOLD-1`.

## Operation
- **States.**
  - IDLE: `VALID=0`, `GNT=0`.
  - GRANT: `VALID=1`, `GNT=1<<C`.
- **Reset values.** State IDLE, `C=2'b11`, `GNT=0`, `VALID=0`, `CNT=0`, `Y=0`. Because `C` resets to 3, requester 0 has top priority for the first arbitration.
- **Round-robin search.** The search starts at index `(C+1) mod 4` and goes upward with wrap-around, ending at `C` itself. The first index with `REQ` high wins. The current holder therefore always has the lowest priority.
- **From IDLE.**
  - If any `REQ` bit is high at the clock edge: go to GRANT, load `C` with the search winner, set `CNT=0`.
  - Otherwise stay in IDLE; `C` keeps its last value.
- **In GRANT, at each edge, evaluated in this order:**
  - `REQ[C]` is 0 (release): run the search over `REQ`.
    - A winner exists: grant it back-to-back, with no idle cycle, and set `CNT=0`.
    - No winner: go to IDLE, `CNT=0`, `C` unchanged.
  - `CNT == MAX_HOLD-1` (quantum expired): run the search over `REQ`.
    - If another requester wins, switch to it.
    - If only requester C is requesting, re-grant C.
    - In both cases set `CNT=0`.
  - Otherwise: stay in GRANT and increment `CNT`.
- **Simultaneous events.**
  - Release and quantum expiry on the same edge are handled as a release.
  - A new request arriving on the same edge as a release takes part in that edge's search.
- **Mid-grant assertion of `RESET_N` low.** All outputs go to their reset values immediately, without waiting for a clock edge. The in-flight grant is lost.
- **Width rule.** `CNT` is 4 bits and never exceeds `MAX_HOLD-1`, so it cannot wrap. When `MAX_HOLD=1` the quantum expires every cycle, giving a strict per-cycle rotation.

## Timing
- Request-to-grant latency from IDLE: 1 cycle. `REQ` is sampled at edge N and `GNT`/`VALID` are high after edge N.
- Handover on release: 1 cycle. The holder drops `REQ` before edge N, and the next holder's `GNT` is high after edge N with no gap.
- Maximum hold with competition: `MAX_HOLD` cycles.
- Worst-case wait for a continuously requesting input: `3*MAX_HOLD` cycles plus 1.
- `GNT`, `C`, `VALID` and `CNT` are registered.
- `Y` is combinational from `X` and the registered `C`/`VALID`. It settles in the same cycle that `X` changes.
- `GNT` is never multi-hot. Both `GNT` and `C` change only on clock edges or on reset assertion.

## Test plan
- **Reset.** Hold `RESET_N=0` with `REQ=4'b1111`, `X=4'b1010` → `GNT=0`, `VALID=0`, `C=3`, `Y=0`. Release reset → after the first edge, `GNT=4'b0001`, `C=0`, `Y=0`.
- **Single requester release.** With `REQ=4'b0100` held for 2 cycles, then 0, and `X=4'b0100` → `GNT=4'b0100` and `Y=1` for 2 cycles, then IDLE with `C=2` retained and `Y=0`.
- **Full rotation under contention.** `REQ=4'b1111` held with `MAX_HOLD=4` → grants go 0,1,2,3,0, each lasting exactly 4 cycles. `CNT` counts 0..3 per grant and there are no gaps.
- **Quantum re-grant.** Only `REQ[1]` high for 10 cycles with `MAX_HOLD=4` → `GNT=4'b0010` continuously, and `CNT` goes 0,1,2,3,0,1,2,3,0,1.
- **Simultaneous release and new request.** Holder 2 drops `REQ` on the same edge that `REQ[0]` and `REQ[3]` rise → the next grant is 3, because the search starts at 3. Grant 0 follows after 3 releases.
- **Reset mid-grant.** Pull `RESET_N` low while `GNT=4'b1000` and `CNT=2` → outputs clear asynchronously without a clock edge. After release with `REQ=4'b1000`, the grant returns to 3 after 1 edge with `CNT=0`.
